// File: rtl/baud_tick_gen.sv
// Integer+fractional baud timing: oversample tick, bit tick and a bit-rate square wave.
// Ticks decode combinationally from the prescale counter; no backpressure, divisor changes land on bit boundaries.
module baud_tick_gen #(
   parameter int DIV_W       = 16,
   parameter int FRAC_W      = 4,
   parameter int OVERSAMPLE  = 16,
   parameter int DEFAULT_DIV = 326
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   output logic              div_pending,
   output logic              div_err,
   output logic              rx_tick,
   output logic              tx_tick,
   output logic              baud_clk
);

   localparam int OS_W = $clog2(OVERSAMPLE);

   typedef struct packed {
      logic [DIV_W-1:0]  whole;
      logic [FRAC_W-1:0] frac;
   } div_t;

   div_t              div_act;
   div_t              div_shd;
   div_t              load_dat;
   logic [DIV_W:0]    cnt;
   logic [DIV_W:0]    period;
   logic [FRAC_W-1:0] acc;
   logic              carry;
   logic [FRAC_W:0]   acc_sum;
   logic [OS_W-1:0]   os_cnt;
   logic [OS_W-1:0]   os_nxt;
   logic              apply;

   // One extra counter bit so a maximal divisor plus carry still fits.
   assign period  = {1'b0, div_act.whole} + (DIV_W+1)'(carry);
   assign acc_sum = {1'b0, acc} + {1'b0, div_act.frac};

   // Gating with reset keeps a period cut short by reset from emitting a tick.
   assign rx_tick = reset && en && (cnt == period - (DIV_W+1)'(1));
   assign tx_tick = rx_tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

   // Idle generator has no bit in flight, so a pending divisor can go in at once.
   assign apply = div_pending && (tx_tick || !en);

   always_comb begin
      load_dat.whole = div_int;
      load_dat.frac  = div_frac;
      if (div_int < DIV_W'(2)) begin
         load_dat.whole = DIV_W'(2);
      end
   end

   always_comb begin
      os_nxt = os_cnt;
      if (!en) begin
         os_nxt = '0;
      end else if (rx_tick) begin
         os_nxt = os_cnt + OS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt      <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         os_cnt   <= '0;
         baud_clk <= 1'b0;
      end else begin
         if (!en) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
         end else if (rx_tick) begin
            cnt          <= '0;
            {carry, acc} <= acc_sum;
         end else begin
            cnt <= cnt + (DIV_W+1)'(1);
         end
         // A freshly applied divisor starts its fractional sequence from zero.
         if (apply) begin
            acc   <= '0;
            carry <= 1'b0;
         end
         os_cnt   <= os_nxt;
         baud_clk <= ~os_nxt[OS_W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_act.whole <= DIV_W'(DEFAULT_DIV);
         div_act.frac  <= '0;
         div_shd       <= '0;
         div_pending   <= 1'b0;
         div_err       <= 1'b0;
      end else begin
         if (apply) begin
            div_act <= div_shd;
         end
         // A load coinciding with an apply survives as the next pending value.
         if (div_load) begin
            div_shd     <= load_dat;
            div_pending <= 1'b1;
            div_err     <= (div_int < DIV_W'(2));
         end else if (apply) begin
            div_pending <= 1'b0;
         end
      end
   end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised, runtime-programmable baud timing generator for the UART transmitter and receiver.
- Divides clk by a programmable integer+fractional divisor to produce an oversample tick (rx_tick) for receiver sampling, a per-bit tick (tx_tick) every OVERSAMPLE oversample ticks, and a 50% duty baud_clk.
- Divisor updates are shadowed and applied only on bit boundaries, so an in-flight bit is never distorted.

Parameters:
- DIV_W, 16, width of integer divisor (clk cycles per oversample tick).
- FRAC_W, 4, width of fractional divisor; fraction = div_frac / 2^FRAC_W.
- OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4.
- DEFAULT_DIV, 326, integer divisor active after reset; must be >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- en  input  1  generator enable.
- div_int  input  DIV_W  requested integer divisor.
- div_frac  input  FRAC_W  requested fractional divisor.
- div_load  input  1  one-cycle strobe; captures div_int/div_frac into shadow.
- div_pending  output  1  shadow holds a divisor not yet applied.
- div_err  output  1  sticky; last load had div_int < 2 (clamped).
- rx_tick  output  1  one-cycle oversample tick.
- tx_tick  output  1  one-cycle bit tick.
- baud_clk  output  1  bit-rate square wave.

Behaviour:
- Reset, sampled on rising clk while reset==0:
  - Active divisor = DEFAULT_DIV.frac 0; shadow cleared.
  - Prescale counter, fractional accumulator acc, carry c and os_cnt all 0.
  - Outputs rx_tick, tx_tick, baud_clk, div_pending and div_err all 0.
  - Reset mid-operation aborts the current period with no trailing tick.
- Prescale period P = div_act + c. The counter runs 0..P-1.
- rx_tick = 1 for exactly the cycle in which counter == P-1 and en == 1. On that cycle:
  - counter <= 0;
  - {c, acc} <= acc + frac_act, using an (FRAC_W+1)-bit add; c is the carry;
  - os_cnt <= os_cnt + 1, modulo OVERSAMPLE.
- The average rx_tick period is div_act + frac_act/2^FRAC_W. The first period after reset or enable is div_act, because c = 0.
- tx_tick = rx_tick && (os_cnt == OVERSAMPLE-1), i.e. coincident with the last oversample tick of a bit.
- baud_clk is registered and equals 1 while os_cnt < OVERSAMPLE/2, else 0. It changes the cycle after the rx_tick that moves os_cnt across the boundary.
- div_load:
  - Captures the inputs into the shadow and sets div_pending.
  - If div_int < 2: shadow integer = 2 and div_err <= 1. Otherwise div_err <= 0.
  - A load while already pending overwrites the shadow; last load wins.
- Apply:
  - On a tx_tick cycle with div_pending == 1: div_act/frac_act <= shadow, acc <= 0, c <= 0, div_pending <= 0. The new period takes effect from the next cycle.
  - While en == 0, a pending shadow is applied on the next cycle.
  - If div_load and tx_tick occur in the same cycle, the new load goes to the shadow and stays pending; the previous shadow, if any, is applied.
- en == 0:
  - counter, acc, c and os_cnt are held at 0; rx_tick and tx_tick are 0; baud_clk is 1 (os_cnt = 0).
  - Dropping en mid-bit discards the partial bit.
  - On re-enable, the first rx_tick comes div_act cycles after en rises.
- Counter compare uses DIV_W+1 bits, so div_act = 2^DIV_W-1 with c = 1 does not overflow.

Test Plan:
- OVERSAMPLE=16, load div_int=3, frac=0, en=1 -> rx_tick every 3 cycles; tx_tick every 48 cycles, coincident with every 16th rx_tick; baud_clk high 24 / low 24.
- FRAC_W=4, div_int=3, div_frac=8 -> rx_tick periods alternate 3,4,3,4; tx_tick spacing exactly 56 cycles.
- Active div 3; at os_cnt=5 load div_int=5 -> div_pending=1; current bit still ends at 48 cycles; the next bit spans 80 cycles; div_pending=0 after that tx_tick.
- Load div_int=1 -> div_err=1; after the boundary rx_tick every 2 cycles. A later load of div_int=4 clears div_err.
- Drop en at os_cnt=7, hold 10 cycles, raise en -> no ticks while low, baud_clk=1; first rx_tick div_act cycles after the rise; tx_tick after 16 rx_ticks.
- Assert reset=0 for one cycle mid-bit after loading div 5 -> all outputs 0 on the next cycle; the divisor reverts to DEFAULT_DIV (326); first rx_tick 326 cycles after reset deasserts with en=1.
